// File: rtl/stream_delay_pkg.sv
// Shared types and constants for the stream delay blocks.
// Used by the ready-delay stage and the LFSR helper.
package stream_delay_pkg;

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Wait = 2'd1,
    Full = 2'd2
  } rdly_state_e;

  localparam int CounterBits = 4;
  localparam logic [15:0] LfsrTaps = 16'hB400;

endpackage

// File: rtl/stream_lfsr16.sv
// 16-bit Galois LFSR with enable and synchronous reset to a seed.
// Full state is exposed so callers can pick whichever bits they need.
module stream_lfsr16
  import stream_delay_pkg::*;
#(
  parameter logic [15:0] Seed = 16'hACE1,
  parameter logic [15:0] Taps = LfsrTaps
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? Taps : 16'h0000);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/stream_ready_delay.sv
// Withholds upstream ready for a fixed or LFSR-chosen number of cycles,
// then holds the captured beat in a one-entry register for downstream.
module stream_ready_delay
  import stream_delay_pkg::*;
#(
  parameter int          StallRandom = 0,
  parameter int unsigned FixedDelay  = 1,
  parameter int unsigned payload_w   = 1,
  parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [payload_w-1:0] payload_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [payload_w-1:0] payload_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  if (FixedDelay > 15) begin : g_bad_delay
    $fatal(1, "FixedDelay must be in 0..15");
  end
  if (LfsrSeed == 16'h0000) begin : g_bad_seed
    $fatal(1, "LfsrSeed must be nonzero");
  end

  localparam logic [CounterBits-1:0] FixedD = CounterBits'(FixedDelay);

  rdly_state_e            state_q, state_d;
  logic [CounterBits-1:0] cnt_q, cnt_d;
  logic [payload_w-1:0]   data_q, data_d;
  logic [CounterBits-1:0] dly;
  logic [15:0]            lfsr;
  logic                   lfsr_en;
  logic                   rdy;
  logic                   unused_lfsr;

  stream_lfsr16 #(
    .Seed (LfsrSeed),
    .Taps (LfsrTaps)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (lfsr_en),
    .state_o (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:CounterBits];
  assign dly = (StallRandom != 0) ? lfsr[CounterBits-1:0] : FixedD;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rdy     = 1'b0;
    lfsr_en = 1'b0;
    unique case (state_q)
      Idle: begin
        if (valid_i) begin
          lfsr_en = 1'b1;
          if (dly == '0) begin
            rdy     = 1'b1;
            data_d  = payload_i;
            state_d = Full;
          end else begin
            cnt_d   = dly - CounterBits'(1);
            state_d = Wait;
          end
        end
      end
      Wait: begin
        rdy = (cnt_q == '0);
        if (rdy && valid_i) begin
          data_d  = payload_i;
          state_d = Full;
        end else if (!valid_i) begin
          // Upstream withdrew: forget the partial countdown.
          cnt_d   = '0;
          state_d = Idle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CounterBits'(1);
        end
      end
      Full: begin
        if (ready_i) begin
          state_d = Idle;
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Idle;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == Wait) begin
      assert (valid_i)
      else $warning("stream_ready_delay: valid_i withdrawn before handshake");
    end
  end

  assign ready_o   = rdy & ~rst_i;
  assign valid_o   = (state_q == Full);
  assign payload_o = data_q;

endmodule

// File: tb/tb_stream_ready_delay.sv
// Directed bench for stream_ready_delay: fixed delays 3/0/2 and LFSR mode.
// Four instances share clock and reset; each test drives one of them.
module tb_stream_ready_delay;

  logic       clk;
  logic       rst;
  logic [7:0] pay_i [4];
  logic       vi    [4];
  logic       ro    [4];
  logic [7:0] po    [4];
  logic       vo    [4];
  logic       ri    [4];

  int n_assert;
  int n_fail;

  stream_ready_delay #(
    .StallRandom (0), .FixedDelay (3), .payload_w (8), .LfsrSeed (16'hACE1)
  ) u_d3 (
    .clk_i (clk), .rst_i (rst), .payload_i (pay_i[0]), .valid_i (vi[0]),
    .ready_o (ro[0]), .payload_o (po[0]), .valid_o (vo[0]), .ready_i (ri[0])
  );

  stream_ready_delay #(
    .StallRandom (0), .FixedDelay (0), .payload_w (8), .LfsrSeed (16'hACE1)
  ) u_d0 (
    .clk_i (clk), .rst_i (rst), .payload_i (pay_i[1]), .valid_i (vi[1]),
    .ready_o (ro[1]), .payload_o (po[1]), .valid_o (vo[1]), .ready_i (ri[1])
  );

  stream_ready_delay #(
    .StallRandom (0), .FixedDelay (2), .payload_w (8), .LfsrSeed (16'hACE1)
  ) u_d2 (
    .clk_i (clk), .rst_i (rst), .payload_i (pay_i[2]), .valid_i (vi[2]),
    .ready_o (ro[2]), .payload_o (po[2]), .valid_o (vo[2]), .ready_i (ri[2])
  );

  stream_ready_delay #(
    .StallRandom (1), .FixedDelay (1), .payload_w (8), .LfsrSeed (16'hACE1)
  ) u_rnd (
    .clk_i (clk), .rst_i (rst), .payload_i (pay_i[3]), .valid_i (vi[3]),
    .ready_o (ro[3]), .payload_o (po[3]), .valid_o (vo[3]), .ready_i (ri[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] t;
    t = {1'b0, s[15:1]};
    if (s[0]) t = t ^ 16'hB400;
    return t;
  endfunction

  task automatic wait_ready(input int idx, output int n);
    n = 0;
    while (!ro[idx] && n < 20) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    logic [15:0] m;
    logic [7:0]  beats [3];
    int          n;
    int          d;
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pay_i[i] = 8'h00;
      vi[i]    = 1'b0;
      ri[i]    = 1'b1;
    end
    repeat (3) cyc();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_ready%0d", i), 32'(ro[i]), 32'd0);
      chk($sformatf("rst_valid%0d", i), 32'(vo[i]), 32'd0);
      chk($sformatf("rst_payload%0d", i), 32'(po[i]), 32'd0);
    end
    rst = 1'b0;
    repeat (5) cyc();

    // FixedDelay = 3: ready at t+3, valid at t+4, idle at t+5
    vi[0] = 1'b1; pay_i[0] = 8'h01;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d3_ready_low_t%0d", k), 32'(ro[0]), 32'd0);
      cyc();
    end
    chk("d3_ready_t3", 32'(ro[0]), 32'd1);
    chk("d3_valid_t3", 32'(vo[0]), 32'd0);
    cyc();
    vi[0] = 1'b0;
    chk("d3_valid_t4", 32'(vo[0]), 32'd1);
    chk("d3_payload_t4", 32'(po[0]), 32'h01);
    chk("d3_ready_t4", 32'(ro[0]), 32'd0);
    cyc();
    chk("d3_idle_t5", 32'(vo[0]), 32'd0);

    // FixedDelay = 0: back-to-back A, B, C
    beats[0] = 8'hA1; beats[1] = 8'hB2; beats[2] = 8'hC3;
    for (int b = 0; b < 3; b++) begin
      vi[1] = 1'b1; pay_i[1] = beats[b];
      #1;
      chk($sformatf("d0_ready_same_cycle%0d", b), 32'(ro[1]), 32'd1);
      chk($sformatf("d0_valid_low%0d", b), 32'(vo[1]), 32'd0);
      cyc();
      chk($sformatf("d0_valid%0d", b), 32'(vo[1]), 32'd1);
      chk($sformatf("d0_payload%0d", b), 32'(po[1]), 32'(beats[b]));
      chk($sformatf("d0_ready_full%0d", b), 32'(ro[1]), 32'd0);
      cyc();
    end
    vi[1] = 1'b0;
    #1;
    chk("d0_idle_after", 32'(vo[1]), 32'd0);

    // FixedDelay = 2 with downstream stalled for 5 cycles
    ri[2] = 1'b0;
    vi[2] = 1'b1; pay_i[2] = 8'h5A;
    #1;
    chk("d2_ready_t0", 32'(ro[2]), 32'd0);
    cyc();
    chk("d2_ready_t1", 32'(ro[2]), 32'd0);
    cyc();
    chk("d2_ready_t2", 32'(ro[2]), 32'd1);
    cyc();
    vi[2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("d2_hold_valid%0d", k), 32'(vo[2]), 32'd1);
      chk($sformatf("d2_hold_payload%0d", k), 32'(po[2]), 32'h5A);
      chk($sformatf("d2_hold_ready%0d", k), 32'(ro[2]), 32'd0);
      cyc();
    end
    ri[2] = 1'b1;
    #1;
    chk("d2_still_valid", 32'(vo[2]), 32'd1);
    cyc();
    chk("d2_released", 32'(vo[2]), 32'd0);

    // LFSR-driven delays, 100 beats, downstream always ready
    m = 16'hACE1;
    for (int k = 0; k < 100; k++) begin
      d = int'(m[3:0]);
      m = lfsr_next(m);
      vi[3] = 1'b1; pay_i[3] = 8'(k);
      #1;
      wait_ready(3, n);
      chk($sformatf("rnd_delay%0d", k), 32'(n), 32'(d));
      cyc();
      vi[3] = 1'b0;
      chk($sformatf("rnd_valid%0d", k), 32'(vo[3]), 32'd1);
      chk($sformatf("rnd_payload%0d", k), 32'(po[3]), 32'(k));
      cyc();
      chk($sformatf("rnd_idle%0d", k), 32'(vo[3]), 32'd0);
    end

    // Reset while Full reloads the seed: delays 1 then 0 again
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    ri[3] = 1'b0;
    vi[3] = 1'b1; pay_i[3] = 8'h77;
    #1;
    wait_ready(3, n);
    chk("rstfull_first_delay", 32'(n), 32'd1);
    cyc();
    vi[3] = 1'b0;
    chk("rstfull_in_full", 32'(vo[3]), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rstfull_valid", 32'(vo[3]), 32'd0);
    chk("rstfull_ready", 32'(ro[3]), 32'd0);
    ri[3] = 1'b1;
    vi[3] = 1'b1; pay_i[3] = 8'h88;
    #1;
    wait_ready(3, n);
    chk("rstfull_reseed_delay", 32'(n), 32'd1);
    cyc();
    vi[3] = 1'b0;
    chk("rstfull_payload", 32'(po[3]), 32'h88);
    cyc();
    vi[3] = 1'b1; pay_i[3] = 8'h99;
    #1;
    wait_ready(3, n);
    chk("rstfull_second_delay", 32'(n), 32'd0);
    cyc();
    vi[3] = 1'b0;
    chk("rstfull_payload2", 32'(po[3]), 32'h99);
    cyc();

    // Reset while Wait with count = 2
    vi[0] = 1'b1; pay_i[0] = 8'h33;
    #1;
    cyc();
    chk("rstwait_ready_before", 32'(ro[0]), 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    vi[0] = 1'b0;
    #1;
    chk("rstwait_ready", 32'(ro[0]), 32'd0);
    chk("rstwait_valid", 32'(vo[0]), 32'd0);
    cyc();

    // valid_i withdrawn during Wait: back to Idle, count discarded
    vi[0] = 1'b1; pay_i[0] = 8'h44;
    #1;
    chk("drop_ready_t0", 32'(ro[0]), 32'd0);
    cyc();
    chk("drop_ready_t1", 32'(ro[0]), 32'd0);
    vi[0] = 1'b0;
    #1;
    chk("drop_ready_dropped", 32'(ro[0]), 32'd0);
    cyc();
    chk("drop_ready_idle", 32'(ro[0]), 32'd0);
    chk("drop_valid_idle", 32'(vo[0]), 32'd0);
    cyc();
    vi[0] = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("drop_retry_low%0d", k), 32'(ro[0]), 32'd0);
      cyc();
    end
    chk("drop_retry_ready", 32'(ro[0]), 32'd1);
    cyc();
    vi[0] = 1'b0;
    chk("drop_retry_valid", 32'(vo[0]), 32'd1);
    chk("drop_retry_payload", 32'(po[0]), 32'h44);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
